oka_mul_arbiter: RTL and testbench

Shares one 32x32 `oka` multiplier between `NREQ` requesters (NTT butterfly / twiddle-update units) using a round-robin arbiter and a pipelined operand/result path. Each requester presents operands on a valid/ready handshake. Each product returns on a single shared response channel tagged with the requester index. The block sits between the butterfly array and the multiplier, and is the only instance of `oka` in the NTT datapath.

---
 rtl/oka_mul_arbiter.sv | 143 ++++++++++++++
 tb/tb_oka_mul_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oka_mul_arbiter.sv
// Round-robin share of one 32x32 Karatsuba (oka) multiplier between NREQ requesters; optional stats via OKA_ARB_STATS_EN.
// Latency: LAT+1 cycles from accept to oRspValid (operand register S0 + LAT result registers).
// Backpressure: oRspValid & ~iRspReady freezes the whole pipeline and withholds every oReqReady.
module oka_mul_arbiter #(
  parameter int wI   = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 2
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [NREQ-1:0]      iReqValid,
  output logic [NREQ-1:0]      oReqReady,
  input  logic [NREQ*wI-1:0]   iReqX,
  input  logic [NREQ*wI-1:0]   iReqY,
  output logic                 oRspValid,
  input  logic                 iRspReady,
  output logic [2*wI-1:0]      oRsp,
  output logic [IDW-1:0]       oRspId
`ifdef OKA_ARB_STATS_EN
  ,
  output logic [31:0]          oGrantCnt,
  output logic [31:0]          oStallCnt
`endif
);

  localparam int H = wI / 2;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic [wI-1:0]  x;
    logic [wI-1:0]  y;
  } op_t;

  typedef struct packed {
    logic            vld;
    logic [IDW-1:0]  id;
    logic [2*wI-1:0] prod;
  } rsp_t;

  // Single-level Karatsuba: three half-width products instead of four.
  function automatic logic [2*wI-1:0] oka(input logic [wI-1:0] a, input logic [wI-1:0] b);
    logic [H:0]       a_sum;
    logic [H:0]       b_sum;
    logic [2*H-1:0]   z0;
    logic [2*H-1:0]   z2;
    logic [2*H+1:0]   zm;
    logic [2*H+1:0]   z1;
    a_sum = {1'b0, a[H-1:0]} + {1'b0, a[wI-1:H]};
    b_sum = {1'b0, b[H-1:0]} + {1'b0, b[wI-1:H]};
    z0    = {{H{1'b0}}, a[H-1:0]} * {{H{1'b0}}, b[H-1:0]};
    z2    = {{H{1'b0}}, a[wI-1:H]} * {{H{1'b0}}, b[wI-1:H]};
    zm    = {{(H+1){1'b0}}, a_sum} * {{(H+1){1'b0}}, b_sum};
    // Middle term is never negative, so the 2H+2-bit subtraction cannot wrap.
    z1    = zm - {2'b00, z0} - {2'b00, z2};
    return {z2, z0} + {{(H-2){1'b0}}, z1, {H{1'b0}}};
  endfunction

  // Requester index at distance off above base, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int k;
    k = int'(base) + off;
    if (k >= NREQ) k = k - NREQ;
    return k[IDW-1:0];
  endfunction

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_vld;
  logic            stall;
  logic            accept;
  logic [wI-1:0]   sel_x_dat;
  logic [wI-1:0]   sel_y_dat;
  logic [2*wI-1:0] prod_dat;
  op_t             s0;
  rsp_t            r_q [LAT];

  // First valid requester at or above ptr, wrapping, wins the grant.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && iReqValid[rr_idx(ptr, i)]) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_idx(ptr, i);
      end
    end
    grant[gnt_id] = gnt_vld;
  end

  assign stall     = oRspValid & ~iRspReady;
  assign accept    = gnt_vld & ~stall & ~iRst;
  assign oReqReady = grant & {NREQ{~stall & ~iRst}};
  assign sel_x_dat = iReqX[int'(gnt_id)*wI +: wI];
  assign sel_y_dat = iReqY[int'(gnt_id)*wI +: wI];
  assign prod_dat  = oka(s0.x, s0.y);

  // Operand register, result stages and round-robin pointer advance together unless stalled.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ptr <= '0;
      s0  <= '0;
      for (int i = 0; i < LAT; i++) r_q[i] <= '0;
    end else if (!stall) begin
      s0.vld <= accept;
      s0.id  <= gnt_id;
      s0.x   <= sel_x_dat;
      s0.y   <= sel_y_dat;
      r_q[0].vld  <= s0.vld;
      r_q[0].id   <= s0.id;
      r_q[0].prod <= prod_dat;
      for (int i = 1; i < LAT; i++) r_q[i] <= r_q[i-1];
      if (accept) ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  assign oRspValid = r_q[LAT-1].vld;
  assign oRspId    = r_q[LAT-1].id;
  assign oRsp      = r_q[LAT-1].prod;

`ifdef OKA_ARB_STATS_EN
  logic [31:0] grant_cnt;
  logic [31:0] stall_cnt;

  // Free-running wrap-around event counters for accepts and stall cycles.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) grant_cnt <= grant_cnt + 32'd1;
      if (stall)  stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign oGrantCnt = grant_cnt;
  assign oStallCnt = stall_cnt;
`endif

endmodule

// File: tb/tb_oka_mul_arbiter.sv
// Scoreboard bench for oka_mul_arbiter: requests are pushed on accept, responses popped on handshake.
// Inputs change 1 time unit after the rising edge; DUT outputs are sampled on the falling edge.
// Covers reset state, single/max operands, fairness, backpressure, mid-flight reset and optional stats.
module tb_oka_mul_arbiter;
  localparam int W    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 2;

  logic                iClk = 1'b0;
  logic                iRst;
  logic [NREQ-1:0]     iReqValid;
  logic [NREQ-1:0]     oReqReady;
  logic [NREQ*W-1:0]   iReqX;
  logic [NREQ*W-1:0]   iReqY;
  logic                oRspValid;
  logic                iRspReady;
  logic [2*W-1:0]      oRsp;
  logic [IDW-1:0]      oRspId;
`ifdef OKA_ARB_STATS_EN
  logic [31:0]         oGrantCnt;
  logic [31:0]         oStallCnt;
`endif

  always #5 iClk = ~iClk;

  oka_mul_arbiter #(.wI(W), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iReqValid (iReqValid),
    .oReqReady (oReqReady),
    .iReqX     (iReqX),
    .iReqY     (iReqY),
    .oRspValid (oRspValid),
    .iRspReady (iRspReady),
    .oRsp      (oRsp),
    .oRspId    (oRspId)
`ifdef OKA_ARB_STATS_EN
    ,
    .oGrantCnt (oGrantCnt),
    .oStallCnt (oStallCnt)
`endif
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    prod;
    int             cyc;
  } exp_t;

  exp_t           sb [$];
  int             nerr = 0;
  int             nchk = 0;
  int             cyc  = 0;
  int             cnt [NREQ];
  logic [W-1:0]   xr [NREQ];
  logic [W-1:0]   yr [NREQ];
  bit             lat_chk = 1'b0;
  bit             ord_chk = 1'b0;
  bit             prev_stall = 1'b0;
  logic [63:0]    prev_rsp;
  logic [IDW-1:0] prev_id;
  int             exp_ord;
  bit             first_seen;
  int             first_acc_id;
  int             first_cyc;
  int             last_cyc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      iReqValid[r]        = (cnt[r] > 0);
      iReqX[r*W +: W]     = xr[r];
      iReqY[r*W +: W]     = yr[r];
    end
  endtask

  function automatic bit busy();
    bit b;
    b = (sb.size() != 0) || oRspValid;
    for (int r = 0; r < NREQ; r++) if (cnt[r] > 0) b = 1'b1;
    return b;
  endfunction

  // One clock: sample handshakes at the falling edge, then update requesters after the rising edge.
  task automatic step();
    logic [NREQ-1:0] acc;
    exp_t            e;
    @(negedge iClk);
    cyc++;
    chk("rdy_onehot", {63'd0, $onehot0(oReqReady)}, 64'd1);
    acc = iReqValid & oReqReady;
    if (oRspValid && iRspReady) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", {63'd0, oRspValid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_dat", oRsp, e.prod);
        chk("rsp_id", {62'd0, oRspId}, {62'd0, e.id});
        if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(LAT + 1));
      end
    end
    if (oRspValid && !iRspReady) begin
      chk("stall_rdy", {60'd0, oReqReady}, 64'd0);
      if (prev_stall) begin
        chk("stall_hold_dat", oRsp, prev_rsp);
        chk("stall_hold_id", {62'd0, oRspId}, {62'd0, prev_id});
      end
    end
    prev_stall = oRspValid && !iRspReady;
    prev_rsp   = oRsp;
    prev_id    = oRspId;
    for (int r = 0; r < NREQ; r++) begin
      if (acc[r]) begin
        e.id   = IDW'(r);
        e.prod = {32'd0, xr[r]} * {32'd0, yr[r]};
        e.cyc  = cyc;
        sb.push_back(e);
        if (ord_chk) begin
          chk("grant_order", 64'(r), 64'(exp_ord));
          exp_ord = (exp_ord + 1) % NREQ;
        end
        if (!first_seen) begin
          first_seen   = 1'b1;
          first_acc_id = r;
          first_cyc    = cyc;
        end
        last_cyc = cyc;
      end
    end
    @(posedge iClk);
    #1;
    for (int r = 0; r < NREQ; r++) begin
      if (acc[r]) begin
        cnt[r]--;
        xr[r] = $urandom;
        yr[r] = $urandom;
      end
    end
    drive();
  endtask

  task automatic drain();
    int n = 0;
    while (busy() && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", {63'd0, n < 300}, 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!oRspValid && n < 20) begin
      step();
      n++;
    end
    chk("rsp_wait_timeout", {63'd0, n < 20}, 64'd1);
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    #1;
    sb.delete();
    prev_stall = 1'b0;
    repeat (2) step();
    iRst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    iRst      = 1'b1;
    iRspReady = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      cnt[r] = 0;
      xr[r]  = '0;
      yr[r]  = '0;
    end
    drive();
    #2;
    chk("rst_rsp_vld", {63'd0, oRspValid}, 64'd0);
    chk("rst_rsp", oRsp, 64'd0);
    chk("rst_rsp_id", {62'd0, oRspId}, 64'd0);
    chk("rst_req_rdy", {60'd0, oReqReady}, 64'd0);
    repeat (2) step();
    iRst = 1'b0;

    // Single request 3*5 with checked latency.
    lat_chk = 1'b1;
    xr[0] = 32'd3; yr[0] = 32'd5; cnt[0] = 1;
    drive();
    drain();

    // Maximum operands.
    xr[2] = 32'hFFFF_FFFF; yr[2] = 32'hFFFF_FFFF; cnt[2] = 1;
    drive();
    drain();

    // Fairness: all requesters continuously valid from a fresh pointer.
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      xr[r] = $urandom; yr[r] = $urandom; cnt[r] = 8;
    end
    ord_chk = 1'b1; exp_ord = 0; first_seen = 1'b0;
    drive();
    drain();
    ord_chk = 1'b0;
    chk("fair_tput", 64'(last_cyc - first_cyc), 64'(4 * 8 - 1));

    // Backpressure: three stall cycles while a response is pending.
    lat_chk = 1'b0;
    cnt[0] = 3; cnt[1] = 2;
    drive();
    wait_rsp();
    iRspReady = 1'b0;
    repeat (3) step();
    iRspReady = 1'b1;
    drain();

    // Reset with two requests in flight.
    lat_chk = 1'b1;
    cnt[0] = 1; cnt[1] = 1;
    drive();
    repeat (2) step();
    cnt[0] = 1; cnt[1] = 1; cnt[3] = 1;
    drive();
    iRst = 1'b1;
    #1;
    chk("mid_rst_rsp_vld", {63'd0, oRspValid}, 64'd0);
    chk("mid_rst_rsp", oRsp, 64'd0);
    chk("mid_rst_rsp_id", {62'd0, oRspId}, 64'd0);
    chk("mid_rst_req_rdy", {60'd0, oReqReady}, 64'd0);
    sb.delete();
    prev_stall = 1'b0;
    repeat (2) step();
    iRst = 1'b0;
    first_seen = 1'b0;
    drain();
    chk("rst_first_grant", 64'(first_acc_id), 64'd0);

`ifdef OKA_ARB_STATS_EN
    // Ten accepts and three stall cycles since reset.
    do_reset();
    lat_chk = 1'b0;
    xr[2] = $urandom; yr[2] = $urandom; cnt[2] = 10;
    drive();
    wait_rsp();
    iRspReady = 1'b0;
    repeat (3) step();
    iRspReady = 1'b1;
    drain();
    chk("grant_cnt", {32'd0, oGrantCnt}, 64'd10);
    chk("stall_cnt", {32'd0, oStallCnt}, 64'd3);
    iRst = 1'b1;
    #1;
    chk("grant_cnt_rst", {32'd0, oGrantCnt}, 64'd0);
    chk("stall_cnt_rst", {32'd0, oStallCnt}, 64'd0);
    repeat (2) step();
    iRst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
